// File: rtl/result_sequencer.sv
// result_sequencer: buffers per-channel solver results and streams each as a framed SPI byte sequence (optional RESULT_SEQ_CHECKSUM_EN appends an XOR checksum byte)
module result_sequencer #(
  parameter int CHANNEL_COUNT = 3,
  parameter int RESULT_BYTES = 3,
  parameter bit ORDERED = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [CHANNEL_COUNT*RESULT_BYTES*8-1:0] result_data,
  input  logic [CHANNEL_COUNT-1:0]                result_valid,
  input  logic [CHANNEL_COUNT-1:0]                result_fail,
  input  logic                                    spi_ready,
  input  logic [CHANNEL_COUNT-1:0]                ss_out,
  output logic [7:0]                              tx_byte,
  output logic                                    tx_byte_valid,
  output logic [CHANNEL_COUNT-1:0]                ss_in,
  output logic [CHANNEL_COUNT-1:0]                chan_done,
  output logic [CHANNEL_COUNT-1:0]                overflow,
  output logic                                    all_done
);
  localparam int CW = CHANNEL_COUNT > 1 ? $clog2(CHANNEL_COUNT) : 1;
  localparam int KW = $clog2(RESULT_BYTES + 3);
  localparam int DW = RESULT_BYTES * 8;
`ifdef RESULT_SEQ_CHECKSUM_EN
  localparam int FRAME_LEN = RESULT_BYTES + 2;
`else
  localparam int FRAME_LEN = RESULT_BYTES + 1;
`endif
  typedef enum logic [1:0] {SELECT, SEND, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] buf_q [CHANNEL_COUNT];
  logic [CHANNEL_COUNT-1:0] fail_q, pending;
  logic [CW-1:0] cur, rr, sel, idx;
  logic [KW-1:0] k;
  logic hit;
  logic [7:0] hdr;
  logic [DW-1:0] cur_buf;
`ifdef RESULT_SEQ_CHECKSUM_EN
  logic [7:0] csum;
`endif
  // Candidate channel: lowest undone when ordered, otherwise first pending after rr (wrapping)
  always_comb begin
    sel = '0;
    idx = '0;
    hit = 1'b0;
    for (int j = CHANNEL_COUNT; j >= 1; j--) begin
      idx = ORDERED ? CW'(j - 1) : CW'((int'(rr) + j) % CHANNEL_COUNT);
      if (ORDERED ? !chan_done[idx] : pending[idx]) begin
        sel = idx;
        hit = 1'b1;
      end
    end
  end
  // Next-state logic; DRAIN waits for the SPI master to release every slave select
  always_comb begin
    state_n = state;
    case (state)
      SELECT: state_n = &chan_done ? DONE : (hit && pending[sel]) ? SEND : SELECT;
      SEND:   state_n = (spi_ready && k == KW'(FRAME_LEN - 1)) ? DRAIN : SEND;
      DRAIN:  state_n = &ss_out ? SELECT : DRAIN;
      default: state_n = DONE;
    endcase
  end
  // Frame byte selection and slave select; both idle whenever no byte is offered
  always_comb begin
    cur_buf = buf_q[cur];
    hdr = fail_q[cur] ? 8'h46 : 8'h50;
    tx_byte_valid = state == SEND;
    tx_byte = !tx_byte_valid ? 8'h00 : k == '0 ? hdr : 8'(cur_buf >> (8 * (RESULT_BYTES - int'(k))));
`ifdef RESULT_SEQ_CHECKSUM_EN
    csum = hdr;
    for (int i = 0; i < RESULT_BYTES; i++) csum = csum ^ cur_buf[i*8 +: 8];
    if (tx_byte_valid && k == KW'(RESULT_BYTES + 1)) tx_byte = csum;
`endif
    ss_in = tx_byte_valid ? ~(CHANNEL_COUNT'(1) << cur) : '1;
  end
  assign all_done = state == DONE;
  // Result capture, channel bookkeeping and frame byte counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= SELECT;
      pending <= '0;
      fail_q <= '0;
      chan_done <= '0;
      overflow <= '0;
      k <= '0;
      cur <= '0;
      rr <= CW'(CHANNEL_COUNT - 1);
    end else begin
      state <= state_n;
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        if (result_valid[c]) begin
          if (pending[c] || chan_done[c]) begin
            overflow[c] <= 1'b1;
          end else begin
            buf_q[c] <= result_data[c*DW +: DW];
            fail_q[c] <= result_fail[c];
            pending[c] <= 1'b1;
          end
        end
      end
      if (state == SELECT && state_n == SEND) begin
        cur <= sel;
        rr <= sel;
        k <= '0;
      end
      if (state == SEND && spi_ready) k <= k + 1'b1;
      if (state == DRAIN && &ss_out) begin
        chan_done[cur] <= 1'b1;
        pending[cur] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_result_sequencer.sv
// tb_result_sequencer: scoreboard bench for an ordered and a round-robin result_sequencer
module tb_result_sequencer;
  typedef struct packed {
    logic [7:0] b;
    logic [2:0] ss;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [71:0] data0 = '0, data1 = '0;
  logic [2:0] valid0 = '0, valid1 = '0, fail0 = '0, fail1 = '0;
  logic spi_ready = 1'b0;
  logic hold = 1'b0;
  logic phase = 1'b0;
  logic started = 1'b0;
  logic [7:0] byte0, byte1, tbyte;
  logic tv0, tv1, tv, ad0, ad1, ad;
  logic [2:0] ss0, ss1, ss, cd0, cd1, cd, ov0, ov1, ov;
  exp_t sb[$];
  exp_t e;
  int nrun = 0;
  int nfail = 0;
  int cnt = 0;
  always #5 clk = ~clk;
  result_sequencer #(.CHANNEL_COUNT(3), .RESULT_BYTES(3), .ORDERED(1'b1)) u0 (
    .clk(clk), .reset_n(reset_n), .result_data(data0), .result_valid(valid0), .result_fail(fail0),
    .spi_ready(spi_ready), .ss_out(hold ? 3'b000 : ss0), .tx_byte(byte0), .tx_byte_valid(tv0),
    .ss_in(ss0), .chan_done(cd0), .overflow(ov0), .all_done(ad0));
  result_sequencer #(.CHANNEL_COUNT(3), .RESULT_BYTES(3), .ORDERED(1'b0)) u1 (
    .clk(clk), .reset_n(reset_n), .result_data(data1), .result_valid(valid1), .result_fail(fail1),
    .spi_ready(spi_ready), .ss_out(ss1), .tx_byte(byte1), .tx_byte_valid(tv1),
    .ss_in(ss1), .chan_done(cd1), .overflow(ov1), .all_done(ad1));
  assign tv = phase ? tv1 : tv0;
  assign tbyte = phase ? byte1 : byte0;
  assign ss = phase ? ss1 : ss0;
  assign cd = phase ? cd1 : cd0;
  assign ov = phase ? ov1 : ov0;
  assign ad = phase ? ad1 : ad0;
  // SPI master model: consume a byte every 4th cycle it is offered
  initial begin
    forever begin
      @(posedge clk);
      #1;
      spi_ready = 1'b0;
      if (tv) begin
        cnt++;
        if (cnt == 4) begin
          spi_ready = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end
  // Monitor: every consumed byte is popped from the scoreboard; idle outputs must be quiet
  always @(negedge clk) begin
    if (started && tv && spi_ready) begin
      nrun++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_byte got %h ss_in %b, nothing expected", tbyte, ss);
      end else begin
        e = sb.pop_front();
        if (tbyte !== e.b || ss !== e.ss) begin
          nfail++;
          $display("FAIL frame_byte got %h ss_in %b expected %h ss_in %b", tbyte, ss, e.b, e.ss);
        end
      end
    end else if (started && !tv) begin
      nrun++;
      if (tbyte !== 8'h00 || ss !== 3'b111) begin
        nfail++;
        $display("FAIL idle_outputs got tx_byte %h ss_in %b expected 00 111", tbyte, ss);
      end
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nrun++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push_frame(input int ch, input logic f, input logic [23:0] d);
    logic [7:0] h;
    logic [2:0] s;
    h = f ? 8'h46 : 8'h50;
    s = ~(3'b001 << ch);
    sb.push_back({h, s});
    for (int i = 2; i >= 0; i--) sb.push_back({d[i*8 +: 8], s});
`ifdef RESULT_SEQ_CHECKSUM_EN
    sb.push_back({h ^ d[23:16] ^ d[15:8] ^ d[7:0], s});
`endif
  endtask
  task automatic issue(input logic d, input int ch, input logic f, input logic [23:0] v);
    if (d) begin
      data1[ch*24 +: 24] = v;
      fail1[ch] = f;
      valid1[ch] = 1'b1;
    end else begin
      data0[ch*24 +: 24] = v;
      fail0[ch] = f;
      valid0[ch] = 1'b1;
    end
    step();
    valid0 = '0;
    valid1 = '0;
  endtask
  task automatic wait_cd(input logic [2:0] want);
    int n;
    n = 0;
    while (cd !== want && n < 2000) begin
      step();
      n++;
    end
    check("wait_chan_done", {29'd0, cd}, {29'd0, want});
  endtask
  task automatic wait_sb();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      step();
      n++;
    end
    check("wait_scoreboard_empty", sb.size(), 0);
  endtask
  initial begin
    repeat (3) step();
    reset_n = 1'b1;
    started = 1'b1;
    check("reset_valid", tv, 0);
    check("reset_ss_in", ss, 3'b111);
    check("reset_tx_byte", tbyte, 0);
    check("reset_chan_done", cd, 0);
    check("reset_overflow", ov, 0);
    check("reset_all_done", ad, 0);
    push_frame(0, 1'b0, 24'h001234);
    issue(1'b0, 0, 1'b0, 24'h001234);
    wait_cd(3'b001);
    issue(1'b0, 2, 1'b0, 24'h0A0B0C);
    repeat (10) step();
    check("ordered_ch2_held", tv, 0);
    check("ordered_ch2_not_done", cd, 3'b001);
    push_frame(1, 1'b1, 24'hABCDEF);
    push_frame(2, 1'b0, 24'h0A0B0C);
    issue(1'b0, 1, 1'b1, 24'hABCDEF);
    issue(1'b0, 1, 1'b0, 24'h111111);
    check("overflow_ch1", ov, 3'b010);
    wait_cd(3'b011);
    hold = 1'b1;
    wait_sb();
    repeat (20) step();
    check("drain_hold_chan_done", cd, 3'b011);
    check("drain_hold_all_done", ad, 0);
    check("drain_hold_valid", tv, 0);
    hold = 1'b0;
    wait_cd(3'b111);
    step();
    check("all_done_set", ad, 1);
    issue(1'b0, 0, 1'b0, 24'h999999);
    check("overflow_after_done", ov, 3'b011);
    check("done_is_terminal", ad, 1);
    sb.push_back({8'h50, 3'b110});
    sb.push_back({8'h12, 3'b110});
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    issue(1'b0, 0, 1'b0, 24'h123456);
    wait_sb();
    reset_n = 1'b0;
    step();
    check("midframe_reset_valid", tv, 0);
    check("midframe_reset_ss_in", ss, 3'b111);
    check("midframe_reset_chan_done", cd, 0);
    check("midframe_reset_overflow", ov, 0);
    reset_n = 1'b1;
    push_frame(0, 1'b0, 24'h123456);
    issue(1'b0, 0, 1'b0, 24'h123456);
    check("resend_no_overflow", ov, 0);
    wait_cd(3'b001);
    phase = 1'b1;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("rr_reset_all_done", ad, 0);
    push_frame(2, 1'b0, 24'h2A2B2C);
    push_frame(1, 1'b0, 24'h1A1B1C);
    issue(1'b1, 2, 1'b0, 24'h2A2B2C);
    issue(1'b1, 1, 1'b0, 24'h1A1B1C);
    wait_cd(3'b110);
    repeat (30) step();
    check("rr_all_done_low", ad, 0);
    check("rr_idle_valid", tv, 0);
    check("rr_chan_done", cd, 3'b110);
    check("scoreboard_empty_end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end
endmodule
